axis_adc_capture_ctrl: RTL and testbench
========================================

# axis_adc_capture_ctrl

Capture sequencer for the free-running ADC sample stream in the LiFi OFDM receiver. It sits between the Red Pitaya ADC AXI-Stream source (two sign-extended 16-bit channels per 32-bit beat, tvalid always high, no tready) and the downstream DMA/FFT path. On an arm command it waits a holdoff, searches for a level crossing on channel A, then forwards exactly `cfg_length` beats framed with `tlast`. It flags any samples dropped by downstream backpressure.

## Interface
- `AXIS_TDATA_WIDTH`, 32: stream width; channel A = `[15:0]`, channel B = `[31:16]`, both two's complement.
- `CNTR_WIDTH`, 16: width of the holdoff and length counters.

- `aclk`  in  1  sole clock.
- `areset`  in  1  reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- `cfg_arm`  in  1  one-cycle start pulse; honoured only in IDLE with `cfg_length != 0`.
- `cfg_force`  in  1  pulse; forces the trigger on the next valid sample while in WAIT_TRIG.
- `cfg_edge`  in  1  0 = rising crossing, 1 = falling crossing.
- `cfg_level`  in  16  signed trigger threshold.
- `cfg_holdoff`  in  CNTR_WIDTH  valid input samples to discard after arm.
- `cfg_length`  in  CNTR_WIDTH  output beats per frame.
- `s_axis_tvalid`  in  1  ADC sample valid.
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  ADC sample.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  output sample.
- `m_axis_tlast`  out  1  final beat of frame.
- `sts_state`  out  2  0 IDLE, 1 HOLDOFF, 2 WAIT_TRIG, 3 CAPTURE.
- `sts_done`  out  1  one-cycle pulse on the `tlast` handshake.
- `sts_overrun`  out  1  sticky; set on any dropped sample; cleared by accepted arm.

## Operation
- **IDLE**
  - `cfg_arm` with `cfg_length != 0` latches `cfg_*`, clears `sts_overrun`, and goes to HOLDOFF.
  - If the latched holdoff is 0, it goes directly to WAIT_TRIG.
  - `cfg_arm` in any other state, or with length 0, is ignored.
- **HOLDOFF**
  - The counter decrements per valid input.
  - The sample that brings the count to 0 causes the move to WAIT_TRIG.
- **WAIT_TRIG**
  - `prev` holds the previous valid channel-A sample.
  - The first valid sample after entry only loads `prev`; no trigger is possible on it.
  - Rising crossing: `prev < level && cur >= level`.
  - Falling crossing: `prev > level && cur <= level`.
  - The comparison is signed, 16-bit.
  - A crossing, or a pending force, moves to CAPTURE. The triggering sample is beat 0 of the frame.
- **CAPTURE**
  - A valid input is loaded into the output register when the register is empty or being accepted this cycle.
  - Otherwise the sample is dropped and `sts_overrun` is set.
  - The beat counter counts loaded beats only, so every frame has exactly `cfg_length` beats.
  - `tlast` is attached to beat `cfg_length-1`.
  - After the last beat is loaded, no further loads occur. The state returns to IDLE on the `tlast` handshake; `sts_done` pulses on that handshake.
- **AXIS rules**: `tdata` and `tlast` are held stable while `tvalid && !tready`. `m_axis_tvalid` is never asserted outside CAPTURE.
- **Force**: a force pulse received in HOLDOFF is remembered and applied on entry to WAIT_TRIG. A force pulse in IDLE is discarded.

## Timing
- **Reset values**: all outputs are 0, state is IDLE, counters are 0, `prev` is invalid.
- **Latency**: a sample on `s_axis` at edge N appears on `m_axis` after edge N, i.e. 1 cycle.
- **Trigger**: detected combinationally on the current sample. The state is CAPTURE after the same edge, and `m_axis_tvalid` rises that edge.
- **Simultaneous events**:
  - Output accept and a new load in the same cycle keep `tvalid` high with no bubble.
  - Arm and force in IDLE in the same cycle: arm is taken, force is discarded.
- **Reset mid-frame**: the next edge clears `tvalid`. The partial frame ends without `tlast`.
- **Counter boundaries**: counters never wrap. `cfg_length = 2^CNTR_WIDTH-1` is supported.

## Structure
- **Shared package `adc_capture_pkg`**:
  - state encoding constants;
  - channel slice constants (`CH_WIDTH=16`, A/B offsets).
- **Sub-module `axis_adc_trig_detect`**:
  - holds `prev` and the prev-valid flag;
  - performs the edge/level comparison;
  - outputs a one-cycle `trig` qualified by `s_axis_tvalid` and `enable`.

## Test plan
- **Rising trigger**: arm with holdoff 0, length 4, level 100, rising edge; channel A ramp 90, 95, 99, 100, 101, 102, 103 → output frame 100, 101, 102, 103, `tlast` on 103, `sts_done` pulse, state returns to 0.
- **Holdoff and falling edge**: holdoff 3, falling edge, level 0; inputs 5, -5 (both during holdoff), then 5, -1 → crossing on -1 only; the holdoff samples never trigger.
- **Force**: `cfg_force` with a constant input of 7, length 2 → frame contains two beats of 7; a force pulse issued during IDLE has no effect.
- **Backpressure**: length 3, `tready` low for 2 cycles after the first beat → `sts_overrun = 1`; exactly 3 beats are delivered with stable data while stalled; `tlast` on the 3rd.
- **Ignored commands**: arm during CAPTURE, and arm with length 0 → no state change and no overrun clear.
- **Reset mid-frame**: `areset` pulsed at beat 2 of a length-8 frame → next cycle `tvalid = 0`, `sts_state = 0`, all status outputs 0.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture sequencer: FSM encoding, channel
// layout of the 32-bit ADC beat, and the signed level-crossing test.
package adc_capture_pkg;

  localparam int CH_WIDTH    = 16;
  localparam int CH_A_OFFSET = 0;
  localparam int CH_B_OFFSET = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLDOFF   = 2'd1,
    ST_WAIT_TRIG = 2'd2,
    ST_CAPTURE   = 2'd3
  } state_e;

  // Signed crossing test; falling=0 looks for prev<level<=cur, falling=1 for prev>level>=cur.
  function automatic logic level_cross(
    input logic                       falling,
    input logic signed [CH_WIDTH-1:0] prev,
    input logic signed [CH_WIDTH-1:0] cur,
    input logic signed [CH_WIDTH-1:0] level
  );
    logic hit;
    if (falling) begin
      hit = (prev > level) && (cur <= level);
    end else begin
      hit = (prev < level) && (cur >= level);
    end
    return hit;
  endfunction

endpackage

// File: rtl/axis_adc_trig_detect.sv
// Channel-A level-crossing detector. Keeps the previous valid sample while
// enabled; the first sample after enable only primes the history, so no
// crossing can be reported on it. A pending force fires on any valid sample.
module axis_adc_trig_detect
  import adc_capture_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       valid_i,
  input  logic signed [CH_WIDTH-1:0] sample_i,
  input  logic signed [CH_WIDTH-1:0] level_i,
  input  logic                       falling_i,
  input  logic                       force_i,
  output logic                       trig_o
);

  logic signed [CH_WIDTH-1:0] prev_q, prev_d;
  logic                       prev_vld_q, prev_vld_d;

  // History update: cleared whenever disabled so re-entry starts unprimed.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (!enable_i) begin
      prev_vld_d = 1'b0;
    end else if (valid_i) begin
      prev_d     = sample_i;
      prev_vld_d = 1'b1;
    end else begin
      prev_vld_d = prev_vld_q;
    end
  end

  // History registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  // Trigger decision on the current sample, qualified by enable and valid.
  always_comb begin
    trig_o = 1'b0;
    if (enable_i && valid_i) begin
      trig_o = force_i || (prev_vld_q && level_cross(falling_i, prev_q, sample_i, level_i));
    end else begin
      trig_o = 1'b0;
    end
  end

endmodule

// File: rtl/axis_adc_capture_ctrl.sv
// Capture sequencer between the free-running ADC stream and the DMA/FFT path:
// arm -> holdoff -> trigger search -> fixed-length framed capture. The output
// is a single skid-less register; samples arriving while it is stalled are
// dropped and flagged in a sticky overrun bit.
module axis_adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_arm,
  input  logic                        cfg_force,
  input  logic                        cfg_edge,
  input  logic [CH_WIDTH-1:0]         cfg_level,
  input  logic [CNTR_WIDTH-1:0]       cfg_holdoff,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic [1:0]                  sts_state,
  output logic                        sts_done,
  output logic                        sts_overrun
);

  state_e                      state_q, state_d;
  logic                        edge_q, edge_d;
  logic signed [CH_WIDTH-1:0]  level_q, level_d;
  logic [CNTR_WIDTH-1:0]       len_q, len_d;
  logic [CNTR_WIDTH-1:0]       hold_cnt_q, hold_cnt_d;
  logic [CNTR_WIDTH-1:0]       beat_cnt_q, beat_cnt_d;
  logic                        force_pend_q, force_pend_d;
  logic                        overrun_q, overrun_d;
  logic                        done_q, done_d;
  logic                        m_tvalid_q, m_tvalid_d;
  logic [AXIS_TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                        m_tlast_q, m_tlast_d;

  logic arm_ok_s, trig_s, fire_s, last_fire_s, more_s, room_s;
  logic load_s, drop_s, hold_dec_s, trig_en_s;
  logic signed [CH_WIDTH-1:0] chan_a_s;
  logic [AXIS_TDATA_WIDTH-1:0] beat_s;

  assign chan_a_s = s_axis_tdata[CH_A_OFFSET +: CH_WIDTH];
  assign beat_s   = {s_axis_tdata[CH_B_OFFSET +: CH_WIDTH], s_axis_tdata[CH_A_OFFSET +: CH_WIDTH]};

  axis_adc_trig_detect u_trig (
    .clk_i     (aclk),
    .rst_i     (areset),
    .enable_i  (trig_en_s),
    .valid_i   (s_axis_tvalid),
    .sample_i  (chan_a_s),
    .level_i   (level_q),
    .falling_i (edge_q),
    .force_i   (force_pend_q),
    .trig_o    (trig_s)
  );

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arm_ok_s) begin
          state_d = (cfg_holdoff == '0) ? ST_WAIT_TRIG : ST_HOLDOFF;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        if (hold_dec_s && (hold_cnt_q == CNTR_WIDTH'(1))) begin
          state_d = ST_WAIT_TRIG;
        end else begin
          state_d = ST_HOLDOFF;
        end
      end
      ST_WAIT_TRIG: begin
        if (trig_s) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT_TRIG;
        end
      end
      ST_CAPTURE: begin
        if (last_fire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output strobes steering the datapath; beat loads stop once the frame is full.
  always_comb begin
    arm_ok_s    = (state_q == ST_IDLE) && cfg_arm && (cfg_length != '0);
    trig_en_s   = (state_q == ST_WAIT_TRIG);
    hold_dec_s  = (state_q == ST_HOLDOFF) && s_axis_tvalid;
    fire_s      = m_tvalid_q && m_axis_tready;
    last_fire_s = fire_s && m_tlast_q;
    more_s      = (beat_cnt_q != len_q);
    room_s      = !m_tvalid_q || m_axis_tready;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    case (state_q)
      ST_WAIT_TRIG: load_s = trig_s;
      ST_CAPTURE: begin
        load_s = s_axis_tvalid && more_s && room_s;
        drop_s = s_axis_tvalid && more_s && !room_s;
      end
      default: begin
        load_s = 1'b0;
        drop_s = 1'b0;
      end
    endcase
  end

  // Datapath next-state: latched config, counters, force memory, output register, status.
  always_comb begin
    edge_d       = edge_q;
    level_d      = level_q;
    len_d        = len_q;
    hold_cnt_d   = hold_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    overrun_d    = overrun_q;
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    done_d       = last_fire_s;
    force_pend_d = force_pend_q;

    if (arm_ok_s) begin
      edge_d     = cfg_edge;
      level_d    = cfg_level;
      len_d      = cfg_length;
      hold_cnt_d = cfg_holdoff;
      beat_cnt_d = '0;
      overrun_d  = 1'b0;
    end else if (hold_dec_s) begin
      hold_cnt_d = hold_cnt_q - CNTR_WIDTH'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end

    // A force only matters in HOLDOFF/WAIT_TRIG and is consumed by the trigger.
    case (state_q)
      ST_HOLDOFF:   force_pend_d = force_pend_q || cfg_force;
      ST_WAIT_TRIG: force_pend_d = trig_s ? 1'b0 : (force_pend_q || cfg_force);
      default:      force_pend_d = 1'b0;
    endcase

    if (load_s) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = beat_s;
      m_tlast_d  = (beat_cnt_q == (len_q - CNTR_WIDTH'(1)));
      beat_cnt_d = beat_cnt_q + CNTR_WIDTH'(1);
    end else if (fire_s) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end else begin
      m_tvalid_d = m_tvalid_q;
    end

    if (drop_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      edge_q       <= 1'b0;
      level_q      <= '0;
      len_q        <= '0;
      hold_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      force_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
      done_q       <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
    end else begin
      edge_q       <= edge_d;
      level_q      <= level_d;
      len_q        <= len_d;
      hold_cnt_q   <= hold_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      force_pend_q <= force_pend_d;
      overrun_q    <= overrun_d;
      done_q       <= done_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tlast_q    <= m_tlast_d;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign sts_state     = state_q;
  assign sts_done      = done_q;
  assign sts_overrun   = overrun_q;

endmodule

// File: tb/tb_axis_adc_capture_ctrl.sv
// Directed bench for the ADC capture sequencer. Inputs change 1 ns after the
// rising edge; outputs are checked there, reflecting the edge just taken.
module tb_axis_adc_capture_ctrl;

  logic        aclk = 1'b0;
  logic        areset, cfg_arm, cfg_force, cfg_edge;
  logic [15:0] cfg_level, cfg_holdoff, cfg_length;
  logic        s_axis_tvalid, m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, sts_done, sts_overrun;
  logic [31:0] m_axis_tdata;
  logic [1:0]  sts_state;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [15:0] CH_B = 16'h5A5A;

  axis_adc_capture_ctrl #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16)) dut (
    .aclk(aclk), .areset(areset), .cfg_arm(cfg_arm), .cfg_force(cfg_force),
    .cfg_edge(cfg_edge), .cfg_level(cfg_level), .cfg_holdoff(cfg_holdoff),
    .cfg_length(cfg_length), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .sts_state(sts_state), .sts_done(sts_done),
    .sts_overrun(sts_overrun)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a);
    s_axis_tvalid = v;
    s_axis_tdata  = {CH_B, a};
  endtask

  task automatic arm(input logic [15:0] hold, input logic [15:0] len, input logic [15:0] lvl, input logic edg);
    cfg_holdoff = hold; cfg_length = len; cfg_level = lvl; cfg_edge = edg;
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; cfg_arm = 1'b0; cfg_force = 1'b0; cfg_edge = 1'b0;
    cfg_level = 16'd0; cfg_holdoff = 16'd0; cfg_length = 16'd0;
    m_axis_tready = 1'b1;
    drive(1'b1, 16'd3);
    tick(); tick();
    areset = 1'b0;
    tick();
    n_vec++; if (sts_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", sts_state); end
    n_vec++; if ({m_axis_tvalid, m_axis_tlast, sts_done, sts_overrun} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b exp 0000", {m_axis_tvalid, m_axis_tlast, sts_done, sts_overrun}); end
    n_vec++; if (m_axis_tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata got %h exp 0", m_axis_tdata); end
  endtask

  task automatic test_rising();
    int pre[3] = '{90, 95, 99};
    int beats[4] = '{100, 101, 102, 103};
    logic [31:0] exp_d;
    drive(1'b0, 16'd0);
    arm(16'd0, 16'd4, 16'd100, 1'b0);
    n_vec++; if (sts_state !== 2'd2) begin n_err++; $display("FAIL rise_arm_state got %0d exp 2", sts_state); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(pre[i]));
      tick();
      n_vec++; if (sts_state !== 2'd2 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rise_pre%0d got state %0d tvalid %b exp 2 0", i, sts_state, m_axis_tvalid); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(beats[i]));
      tick();
      exp_d = {CH_B, 16'(beats[i])};
      n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d) begin n_err++; $display("FAIL rise_beat%0d got %b/%h exp 1/%h", i, m_axis_tvalid, m_axis_tdata, exp_d); end
      n_vec++; if (m_axis_tlast !== (i == 3) || sts_state !== 2'd3) begin n_err++; $display("FAIL rise_last%0d got tlast %b state %0d exp %b 3", i, m_axis_tlast, sts_state, (i == 3)); end
    end
    drive(1'b1, 16'd104);
    tick();
    n_vec++; if (sts_state !== 2'd0 || sts_done !== 1'b1 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rise_end got state %0d done %b tvalid %b exp 0 1 0", sts_state, sts_done, m_axis_tvalid); end
    tick();
    n_vec++; if (sts_done !== 1'b0) begin n_err++; $display("FAIL rise_done_pulse got %b exp 0", sts_done); end
  endtask

  task automatic test_holdoff_falling();
    int hs[3] = '{3, 5, -5};
    logic [1:0] hexp[3] = '{2'd1, 2'd1, 2'd2};
    drive(1'b0, 16'd0);
    arm(16'd3, 16'd2, 16'd0, 1'b1);
    n_vec++; if (sts_state !== 2'd1) begin n_err++; $display("FAIL hold_arm_state got %0d exp 1", sts_state); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(hs[i]));
      tick();
      n_vec++; if (sts_state !== hexp[i]) begin n_err++; $display("FAIL hold_cnt%0d got %0d exp %0d", i, sts_state, hexp[i]); end
    end
    drive(1'b1, 16'd5);
    tick();
    n_vec++; if (sts_state !== 2'd2 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL fall_prime got state %0d tvalid %b exp 2 0", sts_state, m_axis_tvalid); end
    drive(1'b1, 16'hFFFF);
    tick();
    n_vec++; if (sts_state !== 2'd3 || m_axis_tdata !== {CH_B, 16'hFFFF} || m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL fall_trig got state %0d data %h tlast %b exp 3 5a5affff 0", sts_state, m_axis_tdata, m_axis_tlast); end
    drive(1'b1, 16'd9);
    tick();
    n_vec++; if (m_axis_tdata !== {CH_B, 16'd9} || m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL fall_beat1 got %h tlast %b exp 5a5a0009 1", m_axis_tdata, m_axis_tlast); end
    tick();
    n_vec++; if (sts_state !== 2'd0 || sts_done !== 1'b1) begin n_err++; $display("FAIL fall_end got state %0d done %b exp 0 1", sts_state, sts_done); end
  endtask

  task automatic test_force();
    drive(1'b1, 16'd7);
    cfg_force = 1'b1;
    tick();
    n_vec++; if (sts_state !== 2'd0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL force_idle got state %0d tvalid %b exp 0 0", sts_state, m_axis_tvalid); end
    arm(16'd0, 16'd2, 16'd100, 1'b0);
    cfg_force = 1'b0;
    tick(); tick();
    n_vec++; if (sts_state !== 2'd2) begin n_err++; $display("FAIL force_with_arm got state %0d exp 2", sts_state); end
    cfg_force = 1'b1;
    tick();
    cfg_force = 1'b0;
    n_vec++; if (sts_state !== 2'd2) begin n_err++; $display("FAIL force_pend got state %0d exp 2", sts_state); end
    tick();
    n_vec++; if (sts_state !== 2'd3 || m_axis_tdata !== {CH_B, 16'd7} || m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL force_beat0 got state %0d data %h tlast %b exp 3 5a5a0007 0", sts_state, m_axis_tdata, m_axis_tlast); end
    tick();
    n_vec++; if (m_axis_tdata !== {CH_B, 16'd7} || m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL force_beat1 got %h tlast %b exp 5a5a0007 1", m_axis_tdata, m_axis_tlast); end
    tick();
    n_vec++; if (sts_state !== 2'd0 || sts_done !== 1'b1) begin n_err++; $display("FAIL force_end got state %0d done %b exp 0 1", sts_state, sts_done); end
  endtask

  task automatic test_back_to_back_stall();
    drive(1'b0, 16'd0);
    arm(16'd0, 16'd3, 16'd100, 1'b0);
    cfg_force = 1'b1; drive(1'b1, 16'd10);
    tick();
    cfg_force = 1'b0; drive(1'b1, 16'd11);
    tick();
    n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {CH_B, 16'd11}) begin n_err++; $display("FAIL bp_beat0 got %b/%h exp 1/5a5a000b", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'(12 + i));
      tick();
      n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {CH_B, 16'd11} || m_axis_tlast !== 1'b0 || sts_overrun !== 1'b1) begin n_err++; $display("FAIL bp_stall%0d got v%b d%h l%b ovr%b exp 1 5a5a000b 0 1", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, sts_overrun); end
    end
    m_axis_tready = 1'b1;
    drive(1'b1, 16'd14);
    tick();
    n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {CH_B, 16'd14} || m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL bp_beat1 got v%b d%h l%b exp 1 5a5a000e 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    drive(1'b1, 16'd15);
    tick();
    n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {CH_B, 16'd15} || m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL bp_beat2 got v%b d%h l%b exp 1 5a5a000f 1", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    drive(1'b1, 16'd16);
    tick();
    n_vec++; if (sts_state !== 2'd0 || sts_done !== 1'b1 || m_axis_tvalid !== 1'b0 || sts_overrun !== 1'b1) begin n_err++; $display("FAIL bp_end got st%0d done%b v%b ovr%b exp 0 1 0 1", sts_state, sts_done, m_axis_tvalid, sts_overrun); end
  endtask

  task automatic test_ignored_and_reset();
    arm(16'd0, 16'd0, 16'd100, 1'b0);
    n_vec++; if (sts_state !== 2'd0 || sts_overrun !== 1'b1) begin n_err++; $display("FAIL ign_len0 got state %0d ovr %b exp 0 1", sts_state, sts_overrun); end
    arm(16'd0, 16'd8, 16'd100, 1'b0);
    n_vec++; if (sts_state !== 2'd2 || sts_overrun !== 1'b0) begin n_err++; $display("FAIL arm_clears_ovr got state %0d ovr %b exp 2 0", sts_state, sts_overrun); end
    cfg_force = 1'b1; drive(1'b1, 16'd20);
    tick();
    cfg_force = 1'b0; drive(1'b1, 16'd21);
    tick();
    m_axis_tready = 1'b0; drive(1'b1, 16'd22);
    tick();
    n_vec++; if (sts_overrun !== 1'b1 || m_axis_tdata !== {CH_B, 16'd21}) begin n_err++; $display("FAIL ign_drop got ovr %b data %h exp 1 5a5a0015", sts_overrun, m_axis_tdata); end
    m_axis_tready = 1'b1; drive(1'b1, 16'd23);
    cfg_holdoff = 16'd0; cfg_length = 16'd5; cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    n_vec++; if (sts_state !== 2'd3 || sts_overrun !== 1'b1 || m_axis_tdata !== {CH_B, 16'd23}) begin n_err++; $display("FAIL ign_arm_capture got st %0d ovr %b data %h exp 3 1 5a5a0017", sts_state, sts_overrun, m_axis_tdata); end
    drive(1'b1, 16'd24);
    tick();
    n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {CH_B, 16'd24}) begin n_err++; $display("FAIL rst_beat2 got %b/%h exp 1/5a5a0018", m_axis_tvalid, m_axis_tdata); end
    areset = 1'b1; drive(1'b1, 16'd25);
    tick();
    areset = 1'b0;
    n_vec++; if (m_axis_tvalid !== 1'b0 || sts_state !== 2'd0 || m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_mid got v %b st %0d l %b exp 0 0 0", m_axis_tvalid, sts_state, m_axis_tlast); end
    n_vec++; if (sts_done !== 1'b0 || sts_overrun !== 1'b0) begin n_err++; $display("FAIL rst_status got done %b ovr %b exp 0 0", sts_done, sts_overrun); end
    tick();
    n_vec++; if (sts_state !== 2'd0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_after got st %0d v %b exp 0 0", sts_state, m_axis_tvalid); end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_holdoff_falling();
    test_force();
    test_back_to_back_stall();
    test_ignored_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
